// File: rtl/uart_seg_mux_display.sv
// rtl/uart_seg_mux_display.sv - UART-fed multiplexed seven-segment display driver
// Received bytes fill a nibble buffer that is scanned out one digit per dwell period.
module uart_seg_mux_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 25000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_DIG = 1,
  parameter int ASCII_MODE     = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic [6:0]            o_Segment,
  output logic [NUM_DIGITS-1:0] o_DIG,
  output logic                  o_Char_Err
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW_DIG != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [NUM_DIGITS-1:0][3:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      dig_q, dig_d;
  logic                       err_q, err_d;
  logic [4:0]                 hex;
  logic [6:0]                 lit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Returns {accepted, nibble}; letters map to 10..15 via low nibble + 9.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0;
  endfunction

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    hex     = hex_decode(i_RX_Byte);
    if (i_RX_DV) begin
      if (ASCII_MODE == 0) begin
        for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
          data_d[i]  = data_q[i-2];
          valid_d[i] = valid_q[i-2];
        end
        data_d[1]    = i_RX_Byte[7:4];
        data_d[0]    = i_RX_Byte[3:0];
        valid_d[1:0] = 2'b11;
      end else if (hex[4]) begin
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
          data_d[i]  = data_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
        data_d[0]  = hex[3:0];
        valid_d[0] = 1'b1;
      end else if (i_RX_Byte == 8'h0D) begin
        valid_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    // Segments and digit enable come from the same index so they switch together.
    lit   = valid_q[idx_q] ? seg7(data_q[idx_q]) : 7'h00;
    seg_d = (ACTIVE_LOW_SEG != 0) ? ~lit : lit;
    dig_d = (ACTIVE_LOW_DIG != 0) ? ~(DIG_ONE << idx_q) : (DIG_ONE << idx_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
    end
  end

  assign o_Segment  = seg_q;
  assign o_DIG      = dig_q;
  assign o_Char_Err = err_q;
endmodule

// File: tb/tb_uart_seg_mux_display.sv
// tb/tb_uart_seg_mux_display.sv - scoreboard bench for uart_seg_mux_display
// Three instances: raw/active-low, ASCII/active-low, raw/active-high.
module tb_uart_seg_mux_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv_raw = 1'b0, dv_asc = 1'b0, dv_pol = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [6:0] seg_raw, seg_asc, seg_pol;
  logic [3:0] dig_raw, dig_asc, dig_pol;
  logic       err_raw, err_asc, err_pol;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         inst;
    logic [3:0] dig;
    logic [6:0] seg;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  uart_seg_mux_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1), .ASCII_MODE(0)) u_raw (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_DV(dv_raw), .i_RX_Byte(rx_byte),
    .o_Segment(seg_raw), .o_DIG(dig_raw), .o_Char_Err(err_raw));

  uart_seg_mux_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1), .ASCII_MODE(1)) u_asc (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_DV(dv_asc), .i_RX_Byte(rx_byte),
    .o_Segment(seg_asc), .o_DIG(dig_asc), .o_Char_Err(err_asc));

  uart_seg_mux_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0), .ASCII_MODE(0)) u_pol (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_RX_DV(dv_pol), .i_RX_Byte(rx_byte),
    .o_Segment(seg_pol), .o_DIG(dig_pol), .o_Char_Err(err_pol));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the head entry's digit is enabled, compare its segments.
  initial begin
    int         wait_cnt = 0;
    logic [3:0] cd;
    logic [6:0] cs;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        case (sb_q[0].inst)
          0:       begin cd = dig_raw; cs = seg_raw; end
          1:       begin cd = dig_asc; cs = seg_asc; end
          default: begin cd = dig_pol; cs = seg_pol; end
        endcase
        if (cd == sb_q[0].dig) begin
          check(sb_q[0].name, {25'd0, cs}, {25'd0, sb_q[0].seg});
          void'(sb_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 40) begin
            check({sb_q[0].name, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
            wait_cnt = 0;
          end
        end
      end
    end
  end

  task automatic exp4(input int inst, input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0, input string name);
    logic [6:0] segs [4];
    exp_t       e;
    logic [3:0] p;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int d = 0; d < 4; d++) begin
      p = 4'b0001 << d;
      if (inst != 2) p = ~p;
      e.inst = inst;
      e.dig  = p;
      e.seg  = segs[d];
      e.name = $sformatf("%s_d%0d", name, d);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      check("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  // One-cycle strobe; the error pulse must appear after the strobe edge and last one cycle.
  task automatic send(input int inst, input logic [7:0] b, input logic exp_err);
    logic e;
    @(negedge clk);
    rx_byte = b;
    case (inst)
      0: dv_raw = 1'b1;
      1: dv_asc = 1'b1;
      default: dv_pol = 1'b1;
    endcase
    @(negedge clk);
    dv_raw = 1'b0; dv_asc = 1'b0; dv_pol = 1'b0;
    e = (inst == 0) ? err_raw : (inst == 1) ? err_asc : err_pol;
    check($sformatf("err_pulse_%0d_%h", inst, b), {31'd0, e}, {31'd0, exp_err});
    @(negedge clk);
    e = (inst == 0) ? err_raw : (inst == 1) ? err_asc : err_pol;
    check($sformatf("err_clear_%0d_%h", inst, b), {31'd0, e}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_d, prev, det, nxt;
    int         found, n, oh;

    repeat (3) @(negedge clk);
    #2;
    check("rst_seg_raw", {25'd0, seg_raw}, 32'h7F);
    check("rst_dig_raw", {28'd0, dig_raw}, 32'hF);
    check("rst_err_asc", {31'd0, err_asc}, 32'd0);
    check("rst_seg_pol", {25'd0, seg_pol}, 32'h00);
    check("rst_dig_pol", {28'd0, dig_pol}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp_d = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("scan_dig_%0d", k), {28'd0, dig_raw}, {28'd0, exp_d});
      check($sformatf("scan_seg_%0d", k), {25'd0, seg_raw}, 32'h7F);
    end

    send(0, 8'h3A, 1'b0);
    exp4(0, 7'h7F, 7'h7F, 7'h30, 7'h08, "raw_3A");
    drain();
    send(0, 8'h51, 1'b0);
    exp4(0, 7'h30, 7'h08, 7'h12, 7'h79, "raw_51");
    drain();

    // Land the first of two back-to-back strobes on the scan-wrap edge.
    prev = dig_raw; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (dig_raw != prev) found = 1;
    end
    check("wrap_sync", found, 32'd1);
    det = dig_raw;
    @(negedge clk);
    @(negedge clk);
    dv_raw = 1'b1; rx_byte = 8'h12;
    @(negedge clk);
    rx_byte = 8'h34;
    check("wrap_hold", {28'd0, dig_raw}, {28'd0, det});
    @(negedge clk);
    dv_raw = 1'b0;
    nxt = {det[2:0], det[3]};
    check("wrap_advance", {28'd0, dig_raw}, {28'd0, nxt});
    for (int r = 0; r < 2; r++) begin
      prev = dig_raw; n = 0; found = 0;
      for (int i = 0; i < 12 && found == 0; i++) begin
        @(negedge clk);
        n++;
        if (dig_raw != prev) found = 1;
      end
      check($sformatf("wrap_period_%0d", r), n, 32'd4);
    end
    exp4(0, 7'h79, 7'h24, 7'h30, 7'h19, "wrap_1234");
    drain();

    send(0, 8'h3A, 1'b0);
    @(negedge clk);
    #2;
    dv_raw = 1'b1; rx_byte = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_seg", {25'd0, seg_raw}, 32'h7F);
    check("midrst_dig", {28'd0, dig_raw}, 32'hF);
    check("midrst_seg_pol", {25'd0, seg_pol}, 32'h00);
    repeat (2) @(negedge clk);
    dv_raw = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_first_dig", {28'd0, dig_raw}, 32'hE);
    check("rel_first_seg", {25'd0, seg_raw}, 32'h7F);
    exp4(0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "rel_blank");
    drain();

    send(1, 8'h62, 1'b0);
    send(1, 8'h31, 1'b0);
    exp4(1, 7'h7F, 7'h7F, 7'h03, 7'h79, "asc_b1");
    drain();
    send(1, 8'h7A, 1'b1);
    exp4(1, 7'h7F, 7'h7F, 7'h03, 7'h79, "asc_z_keep");
    drain();
    send(1, 8'h0D, 1'b0);
    exp4(1, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "asc_cr");
    drain();

    send(2, 8'h80, 1'b0);
    exp4(2, 7'h00, 7'h00, 7'h7F, 7'h3F, "pol_80");
    drain();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      oh = $countones(dig_pol);
      check($sformatf("pol_onehot_%0d", k), oh, 32'd1);
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_seg_mux_display.md
UART_SEG_MUX_DISPLAY -- requirements
Module: uart_seg_mux_display

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4, giving the number of display digits; legal values are even, 2..8.
REQ-002 The block SHALL have the parameter SCAN_DIV, default 25000, giving clocks per digit dwell; legal values are >= 2.
REQ-003 The block SHALL have the parameter ACTIVE_LOW_SEG, default 1; when 1, a lit segment drives 0.
REQ-004 The block SHALL have the parameter ACTIVE_LOW_DIG, default 1; when 1, an enabled digit drives 0.
REQ-005 The block SHALL have the parameter ASCII_MODE, default 0; 0 selects raw-byte mode and 1 selects ASCII-hex mode.
REQ-006 The block SHALL have the port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have the port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have the port i_RX_DV, input, 1 bit: one-cycle strobe marking i_RX_Byte valid, from the UART receiver.
REQ-009 The block SHALL have the port i_RX_Byte, input, 8 bits: the received byte.
REQ-010 The block SHALL have the port o_Segment, output, 7 bits: segment drive, where bit0 = A, ..., bit6 = G.
REQ-011 The block SHALL have the port o_DIG, output, NUM_DIGITS bits: one-hot digit enable, where bit0 = rightmost digit.
REQ-012 The block SHALL have the port o_Char_Err, output, 1 bit: one-cycle pulse when an ASCII-mode character is rejected.

Function
REQ-013 The block SHALL hold a display buffer of NUM_DIGITS nibbles, each with a valid bit; a digit whose valid bit is 0 SHALL be blank, with all segments unlit.
REQ-014 In raw mode, on each edge with i_RX_DV=1, the buffer SHALL shift up by two digits, load i_RX_Byte[7:4] into digit 1 and i_RX_Byte[3:0] into digit 0, set both valid bits, and discard the top two digits.
REQ-015 In ASCII mode, on each edge with i_RX_DV=1, the characters '0'-'9', 'A'-'F' and 'a'-'f' SHALL shift the buffer up by one digit and load the decoded nibble, marked valid, into digit 0.
REQ-016 In ASCII mode, byte 0x0D SHALL clear all valid bits and leave the buffer data don't-care.
REQ-017 In ASCII mode, any other byte SHALL leave the buffer unchanged and pulse o_Char_Err for exactly one cycle, registered on the edge after the strobe.
REQ-018 In raw mode, o_Char_Err SHALL stay 0.
REQ-019 i_RX_DV high on consecutive cycles SHALL be accepted once per cycle, with no byte dropped.
REQ-020 A scan counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-021 o_Segment and o_DIG SHALL be registered from the same digit index and buffer state, so both change on the same edge with 1-clock latency.
REQ-022 Each digit SHALL therefore be enabled for exactly SCAN_DIV cycles per frame.
REQ-023 Active-high segment encoding SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex); the output SHALL be inverted when ACTIVE_LOW_SEG=1.
REQ-024 A buffer write coinciding with a scan advance SHALL both take effect: the scan timing is unaffected, and the new data appears on o_Segment by the following edge.
REQ-025 Exactly one o_DIG bit SHALL be active at every cycle after the first post-reset edge.

Reset
REQ-026 While i_Rst_n=0, the block SHALL immediately and asynchronously clear all valid bits, the scan counter and the digit index.
REQ-027 While i_Rst_n=0, o_Segment SHALL be all unlit, o_DIG SHALL be all inactive, and o_Char_Err SHALL be 0.
REQ-028 On the first edge after reset release, o_DIG SHALL enable digit 0, with blank segments.
REQ-029 Reset asserted mid-frame or during a strobe SHALL discard that strobe and blank the display at once.

Verification
REQ-030 The bench SHALL cover scan after reset. Config: NUM_DIGITS=4, SCAN_DIV=4, both polarities active-low. Stimulus: release reset. Required response: o_DIG sequence 1110, 1101, 1011, 0111, repeating, 4 cycles each, with o_Segment=7F throughout.
REQ-031 The bench SHALL cover raw mode. Stimulus: strobe 0x3A. Required response: digit1 shows 30 (the '3'), digit0 shows 08 (the 'A'), and digits 2 and 3 show 7F. Then strobe 0x51. Required response: digits 3..0 show 3, A, 5, 1.
REQ-032 The bench SHALL cover ASCII mode. Stimulus: 'b' then '1'. Required response: digit1 shows b, digit0 shows 1. Then 'z'. Required response: o_Char_Err high for exactly 1 cycle and the buffer unchanged. Then 0x0D. Required response: all digits show 7F.
REQ-033 The bench SHALL cover a strobe on a scan wrap. Stimulus: i_RX_DV on the edge where the counter is 3, plus back-to-back strobes 0x12, 0x34. Required response: digits 3..0 show 1, 2, 3, 4, and the o_DIG period is unchanged.
REQ-034 The bench SHALL cover reset mid-operation. Stimulus: load 0x3A, drop i_Rst_n mid-dwell. Required response: same-cycle o_Segment=7F and o_DIG=1111; after release all digits are blank.
REQ-035 The bench SHALL cover polarity. Config: ACTIVE_LOW_SEG=0, ACTIVE_LOW_DIG=0. Stimulus: strobe 0x80. Required response: digit1 shows 7F, digit0 shows 3F, and o_DIG is one-hot active-high.
